// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : fetch/data arbiter in front of a unified L2 memory
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
   parameter int LATENCY    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        ci_rst_n,
   input  logic        ciIReq,
   input  logic [31:0] diIAdr,
   output logic        coIValid,
   output logic [31:0] doIRData,
   input  logic        ciDReq,
   input  logic        ciDWe,
   input  logic [31:0] diDAdr,
   input  logic [31:0] diDWData,
   output logic        coDValid,
   output logic [31:0] doDRData,
   output logic        coMemWe,
   output logic [31:0] doMemAdr,
   output logic [31:0] doMemWData,
   input  logic [31:0] diMemRData
);

   localparam int CNT_W = 4;
   localparam int STV_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] c_cntLast   = CNT_W'(LATENCY - 1);
   localparam logic [STV_W-1:0] c_starveMax = STV_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_nextState;
   logic [CNT_W-1:0]   r_cnt;
   logic [STV_W-1:0]   r_starve;
   logic               r_ownerI;
   logic               r_we;
   logic               w_anyReq;
   logic               w_grantI;

   always_ff @(posedge clk or negedge ci_rst_n) begin
      if (!ci_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Outputs decode only from state and latched registers, never from requests.
   always_comb begin
      w_nextState = r_state;
      w_anyReq    = ciIReq | ciDReq;
      w_grantI    = ciIReq & (~ciDReq | (r_starve == c_starveMax));
      coMemWe     = 1'b0;
      coIValid    = 1'b0;
      coDValid    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_anyReq) begin
               w_nextState = BUSY;
            end
         end
         BUSY: begin
            coMemWe = r_we & (r_cnt == '0);
            if (r_cnt == c_cntLast) begin
               w_nextState = RESP;
            end
         end
         RESP: begin
            coIValid    = r_ownerI;
            coDValid    = ~r_ownerI;
            w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge ci_rst_n) begin
      if (!ci_rst_n) begin
         r_cnt      <= '0;
         r_starve   <= '0;
         r_ownerI   <= 1'b0;
         r_we       <= 1'b0;
         doMemAdr   <= '0;
         doMemWData <= '0;
         doIRData   <= '0;
         doDRData   <= '0;
      end else begin
         if (r_state == IDLE && w_anyReq) begin
            r_ownerI <= w_grantI;
            r_cnt    <= '0;
            if (w_grantI) begin
               doMemAdr <= diIAdr;
               r_we     <= 1'b0;
               r_starve <= '0;
            end else begin
               doMemAdr   <= diDAdr;
               doMemWData <= diDWData;
               r_we       <= ciDWe;
               // D beat a waiting fetch; the counter can't be at max here.
               if (ciIReq) begin
                  r_starve <= r_starve + 1'b1;
               end
            end
         end
         if (r_state == BUSY) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_cntLast) begin
               if (r_ownerI) begin
                  doIRData <= diMemRData;
               end else begin
                  doDRData <= diMemRData;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed bench for mem_arbiter (LATENCY 1 and 3 instances)
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iReq, dReq, dWe;
   logic [31:0] iAdr, dAdr, dWData;

   logic        iValid1, dValid1, memWe1;
   logic [31:0] iRData1, dRData1, memAdr1, memWData1, memRData1;
   logic        iValid3, dValid3, memWe3;
   logic [31:0] iRData3, dRData3, memAdr3, memWData3, memRData3;

   logic [31:0] mem1 [256];
   logic [31:0] mem3 [256];

   int nPass  = 0;
   int nTotal = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.LATENCY(1), .STARVE_MAX(4)) dut1 (
      .clk(clk), .ci_rst_n(rst_n),
      .ciIReq(iReq), .diIAdr(iAdr), .coIValid(iValid1), .doIRData(iRData1),
      .ciDReq(dReq), .ciDWe(dWe), .diDAdr(dAdr), .diDWData(dWData),
      .coDValid(dValid1), .doDRData(dRData1),
      .coMemWe(memWe1), .doMemAdr(memAdr1), .doMemWData(memWData1), .diMemRData(memRData1)
   );

   mem_arbiter #(.LATENCY(3), .STARVE_MAX(4)) dut3 (
      .clk(clk), .ci_rst_n(rst_n),
      .ciIReq(iReq), .diIAdr(iAdr), .coIValid(iValid3), .doIRData(iRData3),
      .ciDReq(dReq), .ciDWe(dWe), .diDAdr(dAdr), .diDWData(dWData),
      .coDValid(dValid3), .doDRData(dRData3),
      .coMemWe(memWe3), .doMemAdr(memAdr3), .doMemWData(memWData3), .diMemRData(memRData3)
   );

   // Unified memory: synchronous write, combinational read, word indexed.
   assign memRData1 = mem1[memAdr1[9:2]];
   assign memRData3 = mem3[memAdr3[9:2]];
   always @(posedge clk) begin
      if (memWe1) mem1[memAdr1[9:2]] <= memWData1;
      if (memWe3) mem3[memAdr3[9:2]] <= memWData3;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTotal++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   typedef struct {
      logic        iReq;
      logic        dReq;
      logic        we;
      logic [31:0] iAdr;
      logic [31:0] dAdr;
      logic [31:0] wData;
      logic        expI;
      logic        expWe;
      logic [31:0] expAdr;
      logic [31:0] expRData;
   } vec_t;

   vec_t vecs [5];

   // One LATENCY=1 transaction: arbitration at t, BUSY t+1, RESP t+2.
   task automatic runVec(input int k, input vec_t v);
      @(negedge clk);
      iReq = v.iReq; dReq = v.dReq; dWe = v.we;
      iAdr = v.iAdr; dAdr = v.dAdr; dWData = v.wData;
      @(posedge clk);
      @(negedge clk);
      iAdr = 32'h0000_03FC; dAdr = 32'h0000_03F8; dWData = 32'hFFFF_FFFF;
      chk($sformatf("v%0d busy memAdr", k), memAdr1, v.expAdr);
      chk($sformatf("v%0d busy memWe", k), 32'(memWe1), 32'(v.expWe));
      chk($sformatf("v%0d busy valids", k), 32'({iValid1, dValid1}), 32'd0);
      if (v.we) chk($sformatf("v%0d memWData", k), memWData1, v.wData);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d resp memWe", k), 32'(memWe1), 32'd0);
      chk($sformatf("v%0d resp valids", k), 32'({iValid1, dValid1}), 32'({v.expI, ~v.expI}));
      chk($sformatf("v%0d rdata", k), v.expI ? iRData1 : dRData1, v.expRData);
      iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
      @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int cyc;

      for (int i = 0; i < 256; i++) begin
         mem1[i] = 32'd0;
         mem3[i] = 32'd0;
      end
      mem1[2]  = 32'h2008_0005;
      mem1[3]  = 32'hCAFE_F00D;
      mem1[4]  = 32'h1234_5678;
      mem1[16] = 32'h1111_1111;
      mem3[5]  = 32'hA5A5_A5A5;

      //            iReq  dReq  we    iAdr          dAdr          wData         expI  expWe expAdr        expRData
      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0000_0008, 32'h2008_0005};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0040, 32'h1111_1111};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_0040, 32'h0,        1'b0, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0000_0010, 32'h1234_5678};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_000C, 32'h0,        1'b0, 1'b0, 32'h0000_000C, 32'hCAFE_F00D};

      rst_n = 1'b0;
      iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
      iAdr = 32'd0; dAdr = 32'd0; dWData = 32'd0;

      // Reset state and quiet idle.
      @(negedge clk);
      chk("rst valids", 32'({iValid1, dValid1, memWe1, iValid3, dValid3, memWe3}), 32'd0);
      chk("rst memAdr", memAdr1 | memAdr3, 32'd0);
      chk("rst memWData", memWData1 | memWData3, 32'd0);
      chk("rst rdata", iRData1 | dRData1 | iRData3 | dRData3, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("idle quiet", 32'({iValid1, dValid1, memWe1}), 32'd0);
      end

      for (int i = 0; i < 5; i++) runVec(i, vecs[i]);

      // Reset in the first BUSY cycle of a write aborts it.
      @(negedge clk);
      dReq = 1'b1; dWe = 1'b1; dAdr = 32'h0000_0080; dWData = 32'h0000_0055;
      @(posedge clk);
      @(negedge clk);
      chk("abort memWe before", 32'(memWe1), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("abort memWe after", 32'(memWe1), 32'd0);
      chk("abort memAdr", memAdr1, 32'd0);
      @(posedge clk);
      @(negedge clk);
      dReq = 1'b0; dWe = 1'b0;
      rst_n = 1'b1;
      chk("abort no commit", mem1[32], 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("abort no valid", 32'({iValid1, dValid1}), 32'd0);
      end

      // Contention: starve restarts from 0, so D,D,D,D,I repeating.
      iReq = 1'b1; dReq = 1'b1; dWe = 1'b0;
      iAdr = 32'h0000_0008; dAdr = 32'h0000_000C;
      k = 0; cyc = 0;
      while (k < 10 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         chk("contend onehot", 32'(iValid1 & dValid1), 32'd0);
         if (iValid1 || dValid1) begin
            chk($sformatf("contend grant%0d", k), 32'(iValid1), 32'((k % 5) == 4));
            chk($sformatf("contend cycle%0d", k), 32'(cyc), 32'(2 + 3 * k));
            chk($sformatf("contend data%0d", k), iValid1 ? iRData1 : dRData1,
                iValid1 ? 32'h2008_0005 : 32'hCAFE_F00D);
            k++;
         end
      end
      chk("contend count", 32'(k), 32'd10);
      iReq = 1'b0; dReq = 1'b0;

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // LATENCY=3: held read gives valid at t+4 and t+9; we never asserted.
      @(negedge clk);
      dReq = 1'b1; dWe = 1'b0; dAdr = 32'h0000_0014;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         chk($sformatf("lat3 rd memWe c%0d", c), 32'(memWe3), 32'd0);
         chk($sformatf("lat3 rd valid c%0d", c), 32'({iValid3, dValid3}), 32'((c == 4) || (c == 9)));
         if (c == 1) chk("lat3 rd memAdr", memAdr3, 32'h0000_0014);
         if (c == 4) chk("lat3 rd data", dRData3, 32'hA5A5_A5A5);
      end
      dReq = 1'b0;

      // LATENCY=3 write: we only in the first BUSY cycle, readback sees new data.
      @(negedge clk);
      dReq = 1'b1; dWe = 1'b1; dAdr = 32'h0000_0014; dWData = 32'h0BAD_CAFE;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         chk($sformatf("lat3 wr memWe c%0d", c), 32'(memWe3), 32'(c == 1));
         chk($sformatf("lat3 wr valid c%0d", c), 32'(dValid3), 32'(c == 4));
         if (c == 4) chk("lat3 wr data", dRData3, 32'h0BAD_CAFE);
      end
      dReq = 1'b0; dWe = 1'b0;
      @(negedge clk);
      chk("lat3 mem commit", mem3[5], 32'h0BAD_CAFE);

      $display("%0d/%0d checks passed", nPass, nTotal);
      $finish;
   end

endmodule
`default_nettype wire
